// File: rtl/game_state_ctrl.sv
// Frogger-style game sequencer: tracks play/dying/level-up/game-over, level, lives and per-lane car speeds.
// Define GAME_STATE_CTRL_SCORE_EN to add a saturating two-digit BCD score; otherwise score is tied to 0x00.
module game_state_ctrl #(
    parameter int                     NUM_LANES  = 11,
    parameter int                     MAX_LEVEL  = 8,
    parameter int                     LIVES      = 3,
    parameter int                     HOLD_TICKS = 30,
    parameter logic [4*NUM_LANES-1:0] LANE_BASE  = {NUM_LANES{4'd12}}
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tick,
    input  logic                     death,
    input  logic                     win,
    input  logic                     restart,
    output logic [3:0]               current_level,
    output logic [1:0]               lives_left,
    output logic [1:0]               state,
    output logic                     round_reset,
    output logic                     game_over,
    output logic [4*NUM_LANES-1:0]   lane_speed,
    output logic [7:0]               score
);

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        DYING     = 2'd1,
        LEVEL_UP  = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam logic [3:0] LEVEL_TOP  = 4'(MAX_LEVEL);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] HOLD_INIT  = 8'(HOLD_TICKS);

    state_t     cur_state;
    state_t     nxt_state;
    logic [3:0] nxt_level;
    logic [1:0] nxt_lives;
    logic [7:0] hold_cnt;
    logic [7:0] nxt_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state     <= PLAY;
            current_level <= 4'd1;
            lives_left    <= LIVES_INIT;
            hold_cnt      <= 8'd0;
        end else begin
            cur_state     <= nxt_state;
            current_level <= nxt_level;
            lives_left    <= nxt_lives;
            hold_cnt      <= nxt_hold;
        end
    end

    // restart overrides everything; death beats win; inputs are only honoured in PLAY
    always_comb begin
        nxt_state = cur_state;
        nxt_level = current_level;
        nxt_lives = lives_left;
        nxt_hold  = hold_cnt;
        if (restart) begin
            nxt_state = PLAY;
            nxt_level = 4'd1;
            nxt_lives = LIVES_INIT;
            nxt_hold  = 8'd0;
        end else begin
            case (cur_state)
                PLAY: begin
                    if (death) begin
                        if (lives_left > 2'd1) begin
                            nxt_lives = lives_left - 2'd1;
                            nxt_state = DYING;
                            nxt_hold  = HOLD_INIT;
                        end else begin
                            nxt_lives = 2'd0;
                            nxt_state = GAME_OVER;
                            nxt_hold  = 8'd0;
                        end
                    end else if (win) begin
                        nxt_state = LEVEL_UP;
                        nxt_hold  = HOLD_INIT;
                        nxt_level = (current_level >= LEVEL_TOP) ? 4'd1 : current_level + 4'd1;
                    end
                end
                DYING, LEVEL_UP: begin
                    if (tick) begin
                        if (hold_cnt <= 8'd1) begin
                            nxt_hold  = 8'd0;
                            nxt_state = PLAY;
                        end else begin
                            nxt_hold  = hold_cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    nxt_state = GAME_OVER;
                end
            endcase
        end
    end

    assign state       = cur_state;
    assign round_reset = (cur_state != PLAY);
    assign game_over   = (cur_state == GAME_OVER);

    // Faster levels shrink the divisor; a divisor of 0 would stall the cars, so floor at 1
    always_comb begin
        lane_speed = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (LANE_BASE[4*i +: 4] > current_level)
                lane_speed[4*i +: 4] = LANE_BASE[4*i +: 4] - current_level;
            else
                lane_speed[4*i +: 4] = 4'd1;
        end
    end

`ifdef GAME_STATE_CTRL_SCORE_EN
    logic [7:0] score_q;
    logic [7:0] score_d;
    logic [7:0] bcd_sum;
    logic [3:0] lvl_tens;
    logic [3:0] lvl_ones;
    logic [4:0] ones_sum;
    logic [4:0] tens_sum;
    logic [3:0] ones_fix;
    logic       ones_carry;
    logic       level_up_event;

    assign level_up_event = (cur_state == PLAY) && win && !death && !restart;

    // Digit-wise BCD add of the pre-increment level, clamped to 99
    always_comb begin
        lvl_tens   = (current_level >= 4'd10) ? 4'd1 : 4'd0;
        lvl_ones   = (current_level >= 4'd10) ? current_level - 4'd10 : current_level;
        ones_sum   = {1'b0, score_q[3:0]} + {1'b0, lvl_ones};
        ones_carry = (ones_sum > 5'd9);
        ones_fix   = ones_carry ? 4'(ones_sum - 5'd10) : ones_sum[3:0];
        tens_sum   = {1'b0, score_q[7:4]} + {1'b0, lvl_tens} + {4'd0, ones_carry};
        bcd_sum    = (tens_sum > 5'd9) ? 8'h99 : {tens_sum[3:0], ones_fix};
    end

    always_comb begin
        score_d = score_q;
        if (restart)
            score_d = 8'h00;
        else if (level_up_event)
            score_d = bcd_sum;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            score_q <= 8'h00;
        else
            score_q <= score_d;
    end

    assign score = score_q;
`else
    assign score = 8'h00;
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios with literal expectations,
// then randomized play checked every cycle against a rule-level model of the game.
module tb_game_state_ctrl;

    localparam int NUM_LANES  = 11;
    localparam int MAX_LEVEL  = 8;
    localparam int LIVES      = 3;
    localparam int HOLD_TICKS = 30;
    localparam logic [4*NUM_LANES-1:0] LANE_BASE =
        {4'd15, 4'd0, 4'd1, 4'd2, 4'd5, 4'd8, 4'd9, 4'd10, 4'd12, 4'd12, 4'd12};

    logic                   clk;
    logic                   reset_n;
    logic                   tick;
    logic                   death;
    logic                   win;
    logic                   restart;
    logic [3:0]             current_level;
    logic [1:0]             lives_left;
    logic [1:0]             state;
    logic                   round_reset;
    logic                   game_over;
    logic [4*NUM_LANES-1:0] lane_speed;
    logic [7:0]             score;

    int n_checks = 0;
    int n_fails  = 0;
    bit cmp_en   = 0;

    int m_state;
    int m_level;
    int m_lives;
    int m_hold;
    int m_score;

    game_state_ctrl #(
        .NUM_LANES (NUM_LANES),
        .MAX_LEVEL (MAX_LEVEL),
        .LIVES     (LIVES),
        .HOLD_TICKS(HOLD_TICKS),
        .LANE_BASE (LANE_BASE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .death        (death),
        .win          (win),
        .restart      (restart),
        .current_level(current_level),
        .lives_left   (lives_left),
        .state        (state),
        .round_reset  (round_reset),
        .game_over    (game_over),
        .lane_speed   (lane_speed),
        .score        (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: state codes 0 play, 1 dying, 2 level-up, 3 game over; score kept in decimal
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_level = 1; m_lives = LIVES; m_hold = 0; m_score = 0;
        end else if (restart) begin
            m_state = 0; m_level = 1; m_lives = LIVES; m_hold = 0; m_score = 0;
        end else if (m_state == 0 && death) begin
            if (m_lives > 1) begin
                m_lives = m_lives - 1; m_state = 1; m_hold = HOLD_TICKS;
            end else begin
                m_lives = 0; m_state = 3; m_hold = 0;
            end
        end else if (m_state == 0 && win) begin
`ifdef GAME_STATE_CTRL_SCORE_EN
            m_score = (m_score + m_level > 99) ? 99 : m_score + m_level;
`endif
            m_level = (m_level % MAX_LEVEL) + 1;
            m_state = 2;
            m_hold  = HOLD_TICKS;
        end else if ((m_state == 1 || m_state == 2) && tick) begin
            m_hold = m_hold - 1;
            if (m_hold == 0) m_state = 0;
        end
    end

    function automatic logic [4*NUM_LANES-1:0] expLanes(input int lvl);
        logic [4*NUM_LANES-1:0] lb;
        logic [4*NUM_LANES-1:0] r;
        int b;
        lb = LANE_BASE;
        r  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            b = int'(lb[4*i +: 4]) - lvl;
            r[4*i +: 4] = 4'((b < 1) ? 1 : b);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("model state", 64'(state), 64'(m_state));
            checkOutput("model level", 64'(current_level), 64'(m_level));
            checkOutput("model lives", 64'(lives_left), 64'(m_lives));
            checkOutput("model hold", 64'(dut.hold_cnt), 64'(m_hold));
            checkOutput("model round_reset", 64'(round_reset), 64'(m_state != 0));
            checkOutput("model game_over", 64'(game_over), 64'(m_state == 3));
            checkOutput("model score", 64'(score), 64'({4'(m_score / 10), 4'(m_score % 10)}));
            checkOutput("model lane_speed", 64'(lane_speed), 64'(expLanes(m_level)));
        end
    end

    task automatic applyStimulus(input logic t, input logic d, input logic w, input logic r);
        @(negedge clk);
        tick = t; death = d; win = w; restart = r;
        @(posedge clk);
        #1;
    endtask

    task automatic holdTicks(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset state", 64'(state), 64'd0);
        checkOutput("async reset lives", 64'(lives_left), 64'd3);
        checkOutput("async reset hold", 64'(dut.hold_cnt), 64'd0);
        checkOutput("async reset level", 64'(current_level), 64'd1);
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        n_fails++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] exp_score [8];
        exp_score = '{8'h01, 8'h03, 8'h06, 8'h10, 8'h15, 8'h21, 8'h28, 8'h36};

        reset_n = 1'b0; tick = 1'b0; death = 1'b0; win = 1'b0; restart = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        #2 reset_n = 1'b1;

        applyStimulus(0, 0, 0, 0);
        checkOutput("reset state", 64'(state), 64'd0);
        checkOutput("reset level", 64'(current_level), 64'd1);
        checkOutput("reset lives", 64'(lives_left), 64'd3);
        checkOutput("reset round_reset", 64'(round_reset), 64'd0);
        checkOutput("reset game_over", 64'(game_over), 64'd0);
        checkOutput("reset score", 64'(score), 64'h00);
        checkOutput("reset lane0", 64'(lane_speed[3:0]), 64'd11);

        applyStimulus(0, 0, 1, 0);
        checkOutput("win state", 64'(state), 64'd2);
        checkOutput("win level", 64'(current_level), 64'd2);
        checkOutput("win round_reset", 64'(round_reset), 64'd1);
        holdTicks(29);
        checkOutput("hold 29 state", 64'(state), 64'd2);
        holdTicks(1);
        checkOutput("hold 30 state", 64'(state), 64'd0);
        checkOutput("hold 30 round_reset", 64'(round_reset), 64'd0);

        applyStimulus(0, 1, 1, 0);
        checkOutput("death+win state", 64'(state), 64'd1);
        checkOutput("death+win lives", 64'(lives_left), 64'd2);
        checkOutput("death+win level", 64'(current_level), 64'd2);
        repeat (30) applyStimulus(1, 1, 0, 0);
        checkOutput("death ignored in hold", 64'(lives_left), 64'd2);
        checkOutput("hold exit with death", 64'(state), 64'd0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("death on reentry state", 64'(state), 64'd1);
        checkOutput("death on reentry lives", 64'(lives_left), 64'd1);
        holdTicks(30);

        applyStimulus(0, 0, 0, 1);
        checkOutput("restart level", 64'(current_level), 64'd1);
        checkOutput("restart lives", 64'(lives_left), 64'd3);
        applyStimulus(0, 1, 0, 0);
        checkOutput("death1 lives", 64'(lives_left), 64'd2);
        holdTicks(30);
        applyStimulus(0, 1, 0, 0);
        checkOutput("death2 lives", 64'(lives_left), 64'd1);
        holdTicks(30);
        applyStimulus(0, 1, 0, 0);
        checkOutput("death3 state", 64'(state), 64'd3);
        checkOutput("death3 lives", 64'(lives_left), 64'd0);
        checkOutput("death3 game_over", 64'(game_over), 64'd1);
        applyStimulus(1, 1, 1, 0);
        holdTicks(40);
        checkOutput("game over holds", 64'(state), 64'd3);
        applyStimulus(0, 0, 0, 1);
        checkOutput("restart from over state", 64'(state), 64'd0);
        checkOutput("restart from over lives", 64'(lives_left), 64'd3);
        checkOutput("restart from over game_over", 64'(game_over), 64'd0);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("win sequence level", 64'(current_level), 64'((k == 7) ? 1 : k + 2));
`ifdef GAME_STATE_CTRL_SCORE_EN
            checkOutput("win sequence score", 64'(score), 64'(exp_score[k]));
`endif
            holdTicks(30);
            if (k == 6) begin
                checkOutput("level8 lane base12", 64'(lane_speed[3:0]), 64'd4);
                checkOutput("level8 lane base8", 64'(lane_speed[23:20]), 64'd1);
                checkOutput("level8 lane base0", 64'(lane_speed[39:36]), 64'd1);
                checkOutput("level8 lane base15", 64'(lane_speed[43:40]), 64'd7);
            end
        end
        for (int k = 0; k < 15; k++) begin
            applyStimulus(0, 0, 1, 0);
            holdTicks(30);
        end
`ifdef GAME_STATE_CTRL_SCORE_EN
        checkOutput("score saturation", 64'(score), 64'h99);
`endif

        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0);
        holdTicks(10);
        checkOutput("mid hold counter", 64'(dut.hold_cnt), 64'd20);
        pulseReset();
        applyStimulus(0, 0, 0, 0);
        checkOutput("after reset state", 64'(state), 64'd0);
        applyStimulus(0, 0, 1, 0);
        holdTicks(5);
        applyStimulus(0, 0, 0, 1);
        checkOutput("restart in level_up state", 64'(state), 64'd0);
        checkOutput("restart in level_up level", 64'(current_level), 64'd1);

        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 499) == 0)
                pulseReset();
            else
                applyStimulus(1'($urandom_range(0, 1)),
                              $urandom_range(0, 7) == 0,
                              $urandom_range(0, 5) == 0,
                              $urandom_range(0, 79) == 0);
        end

        @(negedge clk);
        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
